priority_heap: RTL and testbench

PRIORITY_HEAP -- requirements
Module: priority_heap

---
 rtl/priority_heap_if.sv | 33 +++
 rtl/priority_heap.sv | 192 +++++++++++++++++++
 tb/tb_priority_heap.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_heap_if.sv
// Request/response bundle for priority_heap: insert and extract handshakes plus status.
// The heap itself uses the slave modport and the requester uses the master modport.
interface priority_heap_if #(
  parameter int unsigned KEY_WD  = 16,
  parameter int unsigned TAG_WD  = 8,
  parameter int unsigned ADDR_WD = 4
) ();

  logic                ins_valid;
  logic [KEY_WD-1:0]   ins_key;
  logic [TAG_WD-1:0]   ins_tag;
  logic                ins_ready;
  logic                ext_req;
  logic                ext_valid;
  logic [KEY_WD-1:0]   ext_key;
  logic [TAG_WD-1:0]   ext_tag;
  logic [ADDR_WD-1:0]  count;
  logic                empty;
  logic                full;
  logic                busy;
  logic                err_underflow;

  modport slave (
    input  ins_valid, ins_key, ins_tag, ext_req,
    output ins_ready, ext_valid, ext_key, ext_tag, count, empty, full, busy, err_underflow
  );

  modport master (
    output ins_valid, ins_key, ins_tag, ext_req,
    input  ins_ready, ext_valid, ext_key, ext_tag, count, empty, full, busy, err_underflow
  );

endinterface

// File: rtl/priority_heap.sv
// Binary heap priority queue of {key,tag}. Insert sifts up and extract/replace sift down,
// one level per cycle. MAX_MODE selects between a min-heap and a max-heap.
module priority_heap #(
  parameter int unsigned KEY_WD   = 16,
  parameter int unsigned TAG_WD   = 8,
  parameter int unsigned ADDR_WD  = 4,
  parameter int unsigned DEPTH    = 15,
  parameter bit          MAX_MODE = 1'b0
) (
  input logic             clk,
  input logic             rst,
  priority_heap_if.slave  hif
);

  typedef logic [ADDR_WD:0]   idx_t;
  typedef logic [ADDR_WD-1:0] addr_t;
  typedef enum logic [1:0] {StIdle, StSiftUp, StSiftDown} state_e;

  localparam addr_t FullCnt = addr_t'(DEPTH);
  localparam addr_t Root    = addr_t'(1);

  function automatic logic better(input logic [KEY_WD-1:0] a, input logic [KEY_WD-1:0] b);
    return MAX_MODE ? (a > b) : (a < b);
  endfunction

  logic [KEY_WD-1:0] key_q [2**ADDR_WD];
  logic [TAG_WD-1:0] tag_q [2**ADDR_WD];

  state_e            state_q, state_d;
  idx_t              cursor_q, cursor_d;
  addr_t             count_q, count_d;
  logic              ext_valid_q, ext_valid_d;
  logic [KEY_WD-1:0] ext_key_q, ext_key_d;
  logic [TAG_WD-1:0] ext_tag_q, ext_tag_d;
  logic              err_q, err_d;

  logic              wa_en, wb_en;
  addr_t             wa_idx, wb_idx;
  logic [KEY_WD-1:0] wa_key, wb_key;
  logic [TAG_WD-1:0] wa_tag, wb_tag;

  logic  empty, full;
  idx_t  cnt_ext, lchild, rchild, pick, pick_child;
  addr_t cur, par;
  logic  l_ok, r_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign cnt_ext = {1'b0, count_q};
  assign cur     = cursor_q[ADDR_WD-1:0];
  assign par     = cursor_q[ADDR_WD:1];

  // Children computed one bit wider so 2c+1 cannot wrap; only read when index <= count.
  assign lchild     = {cursor_q[ADDR_WD-1:0], 1'b0};
  assign rchild     = {cursor_q[ADDR_WD-1:0], 1'b1};
  assign l_ok       = (lchild <= cnt_ext);
  assign r_ok       = (rchild <= cnt_ext);
  assign pick       = (r_ok && better(key_q[rchild[ADDR_WD-1:0]], key_q[lchild[ADDR_WD-1:0]]))
                      ? rchild : lchild;
  assign pick_child = {pick[ADDR_WD-1:0], 1'b0};

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    count_d     = count_q;
    ext_valid_d = 1'b0;
    ext_key_d   = ext_key_q;
    ext_tag_d   = ext_tag_q;
    err_d       = 1'b0;
    wa_en       = 1'b0;
    wa_idx      = '0;
    wa_key      = '0;
    wa_tag      = '0;
    wb_en       = 1'b0;
    wb_idx      = '0;
    wb_key      = '0;
    wb_tag      = '0;

    unique case (state_q)
      StIdle: begin
        if (hif.ext_req && !empty) begin
          ext_valid_d = 1'b1;
          ext_key_d   = key_q[Root];
          ext_tag_d   = tag_q[Root];
          cursor_d    = idx_t'(1);
          wa_en       = 1'b1;
          wa_idx      = Root;
          if (hif.ins_valid) begin
            // Replace: new entry takes the root slot, count unchanged.
            wa_key  = hif.ins_key;
            wa_tag  = hif.ins_tag;
            state_d = StSiftDown;
          end else begin
            wa_key  = key_q[count_q];
            wa_tag  = tag_q[count_q];
            count_d = count_q - 1'b1;
            state_d = (count_q > addr_t'(2)) ? StSiftDown : StIdle;
          end
        end else if (hif.ins_valid && !full) begin
          wa_en    = 1'b1;
          wa_idx   = count_q + 1'b1;
          wa_key   = hif.ins_key;
          wa_tag   = hif.ins_tag;
          count_d  = count_q + 1'b1;
          cursor_d = {1'b0, count_q + 1'b1};
          state_d  = StSiftUp;
        end else if (hif.ext_req) begin
          err_d = 1'b1;
        end
      end

      StSiftUp: begin
        state_d = StIdle;
        if (cursor_q > idx_t'(1) && better(key_q[cur], key_q[par])) begin
          wa_en    = 1'b1;
          wa_idx   = par;
          wa_key   = key_q[cur];
          wa_tag   = tag_q[cur];
          wb_en    = 1'b1;
          wb_idx   = cur;
          wb_key   = key_q[par];
          wb_tag   = tag_q[par];
          cursor_d = {1'b0, par};
          // Reaching the root ends the sift without spending an extra compare cycle.
          state_d  = (par == Root) ? StIdle : StSiftUp;
        end
      end

      StSiftDown: begin
        state_d = StIdle;
        if (l_ok && better(key_q[pick[ADDR_WD-1:0]], key_q[cur])) begin
          wa_en    = 1'b1;
          wa_idx   = cur;
          wa_key   = key_q[pick[ADDR_WD-1:0]];
          wa_tag   = tag_q[pick[ADDR_WD-1:0]];
          wb_en    = 1'b1;
          wb_idx   = pick[ADDR_WD-1:0];
          wb_key   = key_q[cur];
          wb_tag   = tag_q[cur];
          cursor_d = pick;
          // A leaf has nothing below it, so stop now.
          state_d  = (pick_child > cnt_ext) ? StIdle : StSiftDown;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cursor_q    <= '0;
      count_q     <= '0;
      ext_valid_q <= 1'b0;
      ext_key_q   <= '0;
      ext_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      count_q     <= count_d;
      ext_valid_q <= ext_valid_d;
      ext_key_q   <= ext_key_d;
      ext_tag_q   <= ext_tag_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (wa_en) begin
      key_q[wa_idx] <= wa_key;
      tag_q[wa_idx] <= wa_tag;
    end
    if (wb_en) begin
      key_q[wb_idx] <= wb_key;
      tag_q[wb_idx] <= wb_tag;
    end
  end

  assign hif.ins_ready     = (state_q == StIdle) && !full;
  assign hif.ext_valid     = ext_valid_q;
  assign hif.ext_key       = ext_key_q;
  assign hif.ext_tag       = ext_tag_q;
  assign hif.count         = count_q;
  assign hif.empty         = empty;
  assign hif.full          = full;
  assign hif.busy          = (state_q != StIdle);
  assign hif.err_underflow = err_q;

endmodule

// File: tb/tb_priority_heap.sv
// Bench for priority_heap: a min-heap and a max-heap instance checked against a
// queue-based reference model, with directed scenarios followed by random traffic.
module tb_priority_heap;

  localparam int unsigned KW    = 16;
  localparam int unsigned TW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // mx selects which instance the request tasks drive and observe.
  logic          mx = 1'b0;
  logic          ins_valid = 1'b0;
  logic          ext_req = 1'b0;
  logic [KW-1:0] ins_key = '0;
  logic [TW-1:0] ins_tag = '0;

  priority_heap_if #(.KEY_WD(KW), .TAG_WD(TW), .ADDR_WD(AW)) hmin ();
  priority_heap_if #(.KEY_WD(KW), .TAG_WD(TW), .ADDR_WD(AW)) hmax ();

  assign hmin.ins_valid = ins_valid & ~mx;
  assign hmin.ext_req   = ext_req & ~mx;
  assign hmin.ins_key   = ins_key;
  assign hmin.ins_tag   = ins_tag;
  assign hmax.ins_valid = ins_valid & mx;
  assign hmax.ext_req   = ext_req & mx;
  assign hmax.ins_key   = ins_key;
  assign hmax.ins_tag   = ins_tag;

  priority_heap #(.KEY_WD(KW), .TAG_WD(TW), .ADDR_WD(AW), .DEPTH(DEPTH), .MAX_MODE(1'b0)) u_min (
    .clk (clk),
    .rst (rst),
    .hif (hmin)
  );

  priority_heap #(.KEY_WD(KW), .TAG_WD(TW), .ADDR_WD(AW), .DEPTH(DEPTH), .MAX_MODE(1'b1)) u_max (
    .clk (clk),
    .rst (rst),
    .hif (hmax)
  );

  logic          o_ready, o_valid, o_empty, o_full, o_busy, o_err;
  logic [KW-1:0] o_key;
  logic [TW-1:0] o_tag;
  logic [AW-1:0] o_count;

  assign o_ready = mx ? hmax.ins_ready     : hmin.ins_ready;
  assign o_valid = mx ? hmax.ext_valid     : hmin.ext_valid;
  assign o_key   = mx ? hmax.ext_key       : hmin.ext_key;
  assign o_tag   = mx ? hmax.ext_tag       : hmin.ext_tag;
  assign o_count = mx ? hmax.count         : hmin.count;
  assign o_empty = mx ? hmax.empty         : hmin.empty;
  assign o_full  = mx ? hmax.full          : hmin.full;
  assign o_busy  = mx ? hmax.busy          : hmin.busy;
  assign o_err   = mx ? hmax.err_underflow : hmin.err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [KW-1:0] m_key [$];
  logic [TW-1:0] m_tag [$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_key.delete();
    m_tag.delete();
  endtask

  // Removes the best entry from the model and checks the returned pair against it.
  task automatic model_pop(input logic [KW-1:0] gk, input logic [TW-1:0] gt);
    int bi = 0;
    int found = -1;
    for (int i = 1; i < m_key.size(); i++)
      if (mx ? (m_key[i] > m_key[bi]) : (m_key[i] < m_key[bi])) bi = i;
    check("ext_key", gk, m_key[bi]);
    for (int i = 0; i < m_key.size(); i++)
      if (found < 0 && m_key[i] == gk && m_tag[i] == gt) found = i;
    check("ext_tag_match", found >= 0, 1);
    if (found < 0) found = bi;
    m_key.delete(found);
    m_tag.delete(found);
  endtask

  // One request in IDLE, then waits for the sift; cyc = cycles spent busy.
  task automatic op(input bit ins, input bit ext, input logic [KW-1:0] k,
                    input logic [TW-1:0] t, output logic [KW-1:0] gk,
                    output logic [TW-1:0] gt, output int cyc);
    int   size = m_key.size();
    logic vld, err;
    check("ins_ready", o_ready, size < DEPTH);
    ins_valid = ins;
    ext_req   = ext;
    ins_key   = k;
    ins_tag   = t;
    step();
    ins_valid = 1'b0;
    ext_req   = 1'b0;
    vld = o_valid;
    err = o_err;
    gk  = o_key;
    gt  = o_tag;
    if (ext && size > 0) begin
      check("ext_valid", vld, 1);
      check("no_underflow", err, 0);
      model_pop(gk, gt);
      if (ins) begin
        m_key.push_back(k);
        m_tag.push_back(t);
      end
    end else if (ext && !ins) begin
      check("underflow", err, 1);
      check("no_ext_valid", vld, 0);
    end else begin
      check("no_ext_valid", vld, 0);
      check("no_underflow", err, 0);
      if (ins && size < DEPTH) begin
        m_key.push_back(k);
        m_tag.push_back(t);
      end
    end
    cyc = 0;
    while (o_busy && cyc < 20) begin
      cyc++;
      step();
    end
    check("sift_done", o_busy, 0);
    check("count", o_count, m_key.size());
    check("empty", o_empty, m_key.size() == 0);
    check("full", o_full, m_key.size() == DEPTH);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [KW-1:0] gk;
    logic [TW-1:0] gt;
    int            cyc;
    int            s1_in  [5] = '{9, 4, 7, 1, 8};
    int            s1_key [5] = '{1, 4, 7, 8, 9};
    int            s1_tag [5] = '{3, 1, 2, 4, 0};
    int            mx_key [3] = '{10, 3, 3};

    do_reset();
    check("rst_count", o_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_key", o_key, 0);
    check("rst_tag", o_tag, 0);

    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, KW'(s1_in[i]), TW'(i), gk, gt, cyc);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'b1, '0, '0, gk, gt, cyc);
      check("s1_key", gk, s1_key[i]);
      check("s1_tag", gt, s1_tag[i]);
    end
    step();
    check("hold_valid", o_valid, 0);
    check("hold_key", o_key, 9);
    check("hold_tag", o_tag, 0);

    mx = 1'b1;
    do_reset();
    op(1'b1, 1'b0, 16'd3, 8'd0, gk, gt, cyc);
    op(1'b1, 1'b0, 16'd3, 8'd1, gk, gt, cyc);
    op(1'b1, 1'b0, 16'd10, 8'd2, gk, gt, cyc);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b1, '0, '0, gk, gt, cyc);
      check("max_key", gk, mx_key[i]);
    end
    mx = 1'b0;

    do_reset();
    for (int i = 0; i < DEPTH; i++)
      op(1'b1, 1'b0, KW'($urandom_range(1, 200)), TW'(i), gk, gt, cyc);
    check("fill_full", o_full, 1);
    check("fill_ready", o_ready, 0);
    check("fill_count", o_count, DEPTH);
    op(1'b1, 1'b0, 16'd1, 8'd99, gk, gt, cyc);
    op(1'b1, 1'b1, 16'd0, 8'd77, gk, gt, cyc);
    check("replace_count", o_count, DEPTH);
    op(1'b0, 1'b1, '0, '0, gk, gt, cyc);
    check("replace_zero_key", gk, 0);
    check("replace_zero_tag", gt, 77);

    do_reset();
    op(1'b0, 1'b1, '0, '0, gk, gt, cyc);
    check("uf_count", o_count, 0);
    step();
    check("uf_single_pulse", o_err, 0);
    op(1'b1, 1'b1, 16'd42, 8'd5, gk, gt, cyc);
    op(1'b0, 1'b1, '0, '0, gk, gt, cyc);
    check("both_empty_key", gk, 42);

    do_reset();
    for (int k = DEPTH; k >= 1; k--) begin
      op(1'b1, 1'b0, KW'(k), TW'(k), gk, gt, cyc);
      check("sift_up_le3", cyc <= 3, 1);
    end
    op(1'b0, 1'b1, '0, '0, gk, gt, cyc);
    check("desc_root", gk, 1);
    check("sift_down_le3", cyc <= 3, 1);

    ext_req = 1'b1;
    step();
    ext_req = 1'b0;
    check("mid_valid", o_valid, 1);
    check("mid_key", o_key, 2);
    check("mid_busy", o_busy, 1);
    do_reset();
    check("mid_rst_count", o_count, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_empty", o_empty, 1);
    check("mid_rst_ready", o_ready, 1);
    op(1'b1, 1'b0, 16'd5, 8'd9, gk, gt, cyc);
    op(1'b0, 1'b1, '0, '0, gk, gt, cyc);
    check("post_rst_key", gk, 5);
    check("post_rst_tag", gt, 9);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 9);
      op(r < 5 || r >= 8, r >= 5, KW'($urandom_range(0, 31)), TW'($urandom_range(0, 255)),
         gk, gt, cyc);
      check("rand_sift_le3", cyc <= 3, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
